stopwatch_counter: RTL and testbench

Time-keeping core of the stopwatch: counts MM:SS from 00:00 to 59:59 as four BCD digits. It sits directly downstream of the clock divider. It consumes that block's 1 Hz and 2 Hz square-wave outputs as data signals sampled on src_clk; they are never used as clocks. Start/pause and an adjust mode with a minutes/seconds field select are supported. The BCD digits feed the seven-segment display driver.

---
 rtl/stopwatch_counter.sv | 139 +++++++++++++
 tb/tb_stopwatch_counter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_counter.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_counter
// Description : MM:SS BCD time-keeping core. Counts 00:00..59:59 on rising
//               edges of the 1 Hz divider output, supports run/pause and a
//               per-field adjust mode stepped by the 2 Hz divider output.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_counter (
    input  logic       src_clk,
    input  logic       reset,
    input  logic       clk_1hz,
    input  logic       clk_2hz,
    input  logic       pause,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       rollover
);

    localparam logic [0:0] ST_PAUSED = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;

    logic       c1_q, c1_d;
    logic       c2_q, c2_d;
    logic [0:0] state_q, state_d;
    logic [3:0] min_tens_q, min_tens_d;
    logic [3:0] min_ones_q, min_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] sec_ones_q, sec_ones_d;
    logic       rollover_q, rollover_d;

    logic       w_tick1;
    logic       w_tick2;
    logic       w_count_en;
    logic       w_adj_en;
    logic [7:0] w_sec_inc;
    logic [7:0] w_min_inc;
    logic       w_sec_wrap;
    logic       w_min_wrap;

    // Two-digit BCD increment over 00..59. Out-of-range digits fold back to
    // zero so a corrupted value can never persist.
    function automatic logic [7:0] bcd_inc60(input logic [3:0] tens,
                                             input logic [3:0] ones);
        logic [3:0] t;
        logic [3:0] o;
        t = tens;
        o = ones;
        if (ones >= 4'd9) begin
            o = 4'd0;
            if (tens >= 4'd5) begin
                t = 4'd0;
            end else begin
                t = tens + 4'd1;
            end
        end else begin
            o = ones + 4'd1;
            if (tens > 4'd5) begin
                t = 4'd0;
            end
        end
        return {t, o};
    endfunction

    // Rising-edge detection on the divider outputs plus increment helpers.
    always_comb begin
        w_tick1    = clk_1hz & ~c1_q;
        w_tick2    = clk_2hz & ~c2_q;
        w_count_en = ~adj & (state_q == ST_RUN) & w_tick1;
        w_adj_en   = adj & w_tick2;
        w_sec_inc  = bcd_inc60(sec_tens_q, sec_ones_q);
        w_min_inc  = bcd_inc60(min_tens_q, min_ones_q);
        w_sec_wrap = (sec_tens_q == 4'd5) && (sec_ones_q == 4'd9);
        w_min_wrap = (min_tens_q == 4'd5) && (min_ones_q == 4'd9);
    end

    // Next-state logic: pause toggle, normal cascade count, field adjust.
    always_comb begin
        c1_d       = clk_1hz;
        c2_d       = clk_2hz;
        state_d    = pause ? ~state_q : state_q;
        min_tens_d = min_tens_q;
        min_ones_d = min_ones_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;
        rollover_d = 1'b0;

        if (w_count_en) begin
            {sec_tens_d, sec_ones_d} = w_sec_inc;
            if (w_sec_wrap) begin
                {min_tens_d, min_ones_d} = w_min_inc;
                rollover_d = w_min_wrap;
            end
        end else if (w_adj_en) begin
            // Fields adjust independently: no carry, no rollover.
            if (sel) begin
                {sec_tens_d, sec_ones_d} = w_sec_inc;
            end else begin
                {min_tens_d, min_ones_d} = w_min_inc;
            end
        end
    end

    // State registers. Edge-detect history tracks the inputs even in reset so
    // a level already high at release does not look like a fresh edge.
    always_ff @(posedge src_clk) begin
        c1_q <= c1_d;
        c2_q <= c2_d;
        if (reset) begin
            state_q    <= ST_RUN;
            min_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            sec_ones_q <= 4'd0;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            min_tens_q <= min_tens_d;
            min_ones_q <= min_ones_d;
            sec_tens_q <= sec_tens_d;
            sec_ones_q <= sec_ones_d;
            rollover_q <= rollover_d;
        end
    end

    assign min_tens = min_tens_q;
    assign min_ones = min_ones_q;
    assign sec_tens = sec_tens_q;
    assign sec_ones = sec_ones_q;
    assign running  = (state_q == ST_RUN);
    assign rollover = rollover_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_counter
// Description : Directed self-checking bench for stopwatch_counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_counter;

    logic       src_clk = 1'b0;
    logic       reset;
    logic       clk_1hz;
    logic       clk_2hz;
    logic       pause;
    logic       adj;
    logic       sel;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       rollover;

    int total = 0;
    int bad   = 0;

    stopwatch_counter dut (
        .src_clk  (src_clk),
        .reset    (reset),
        .clk_1hz  (clk_1hz),
        .clk_2hz  (clk_2hz),
        .pause    (pause),
        .adj      (adj),
        .sel      (sel),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .running  (running),
        .rollover (rollover)
    );

    always #5 src_clk = ~src_clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge src_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare the displayed time against minutes/seconds given in decimal.
    task automatic check_time(input string tag, input int m, input int s);
        logic [15:0] exp;
        exp = {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
        check(tag, {16'd0, min_tens, min_ones, sec_tens, sec_ones},
              {16'd0, exp});
    endtask

    task automatic tick1();
        clk_1hz = 1'b1; step();
        clk_1hz = 1'b0; step();
    endtask

    task automatic tick2_n(input int n);
        for (int i = 0; i < n; i++) begin
            clk_2hz = 1'b1; step();
            clk_2hz = 1'b0; step();
        end
    endtask

    task automatic pulse_pause();
        pause = 1'b1; step();
        pause = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clk_1hz = 1'b0; clk_2hz = 1'b0;
        pause = 1'b0; adj = 1'b0; sel = 1'b0;
        step(); step();
        check_time("reset_digits", 0, 0);
        check("reset_running", {31'd0, running}, 32'd1);
        check("reset_rollover", {31'd0, rollover}, 32'd0);
        reset = 1'b0; step();
        check_time("idle_after_reset", 0, 0);

        // Ten rising edges: one increment each, visible one cycle after.
        for (int i = 1; i <= 10; i++) begin
            clk_1hz = 1'b1; step();
            check_time("count_edge", 0, i);
            step();
            check_time("count_held_high", 0, i);
            clk_1hz = 1'b0; step();
            check_time("count_falling", 0, i);
        end
        check("count_running", {31'd0, running}, 32'd1);

        // Preload 59:58 from 00:10 through adjust.
        adj = 1'b1; sel = 1'b0; tick2_n(59);
        check_time("preload_min", 59, 10);
        sel = 1'b1; tick2_n(48);
        check_time("preload_sec", 59, 58);
        adj = 1'b0; step();
        tick1();
        check_time("pre_wrap", 59, 59);
        check("pre_wrap_rollover", {31'd0, rollover}, 32'd0);
        clk_1hz = 1'b1; step();
        check_time("wrap", 0, 0);
        check("wrap_rollover", {31'd0, rollover}, 32'd1);
        clk_1hz = 1'b0; step();
        check("rollover_one_cycle", {31'd0, rollover}, 32'd0);

        // Pause, ticks ignored; resume, exactly three counted.
        pulse_pause(); step();
        check("paused_running", {31'd0, running}, 32'd0);
        for (int i = 0; i < 5; i++) tick1();
        check_time("paused_hold", 0, 0);
        pulse_pause(); step();
        check("resumed_running", {31'd0, running}, 32'd1);
        for (int i = 0; i < 3; i++) tick1();
        check_time("resumed_count", 0, 3);

        // Seconds adjust from 00:57 with clk_1hz edges alongside (ignored).
        adj = 1'b1; sel = 1'b1; tick2_n(54);
        check_time("adj_sec_start", 0, 57);
        for (int i = 0; i < 4; i++) begin
            clk_1hz = 1'b1; clk_2hz = 1'b1; step();
            check_time("adj_sec_step", 0, (58 + i) % 60);
            clk_1hz = 1'b0; clk_2hz = 1'b0; step();
        end
        check("adj_no_rollover", {31'd0, rollover}, 32'd0);
        // Minutes adjust from 58:01 wraps without touching seconds.
        sel = 1'b0; tick2_n(58);
        check_time("adj_min_58", 58, 1);
        tick2_n(1);
        check_time("adj_min_59", 59, 1);
        tick2_n(1);
        check_time("adj_min_wrap", 0, 1);
        check("adj_keeps_run", {31'd0, running}, 32'd1);

        // Simultaneous pause + tick1 from RUN at 00:05.
        sel = 1'b1; tick2_n(4);
        adj = 1'b0; step();
        check_time("sim_start", 0, 5);
        pause = 1'b1; clk_1hz = 1'b1; step();
        pause = 1'b0; clk_1hz = 1'b0;
        check_time("sim_run_count", 0, 6);
        check("sim_run_state", {31'd0, running}, 32'd0);
        step();
        // Same from PAUSED at 00:05 (adjust 06 -> 05 by wrapping).
        adj = 1'b1; tick2_n(59);
        adj = 1'b0; step();
        check_time("sim_paused_start", 0, 5);
        pause = 1'b1; clk_1hz = 1'b1; step();
        pause = 1'b0; clk_1hz = 1'b0;
        check_time("sim_paused_count", 0, 5);
        check("sim_paused_state", {31'd0, running}, 32'd1);
        step();
        // adj rising with a tick1 in the same cycle blocks the count.
        adj = 1'b1; clk_1hz = 1'b1; step();
        check_time("adj_same_cycle", 0, 5);
        clk_1hz = 1'b0; step();

        // Reset at 12:34 with clk_1hz high; no spurious tick after release.
        sel = 1'b0; tick2_n(12);
        sel = 1'b1; tick2_n(29);
        adj = 1'b0; step();
        check_time("pre_reset", 12, 34);
        clk_1hz = 1'b1; reset = 1'b1; step();
        check_time("reset_priority", 0, 0);
        step();
        reset = 1'b0; step(); step();
        check_time("no_spurious_tick", 0, 0);
        clk_1hz = 1'b0; step();
        clk_1hz = 1'b1; step();
        check_time("first_real_tick", 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
